// File: rtl/mpp_prog_mem.sv
// Program memory for the mpp processor: chip-select driven fetches with
// programmable wait states, plus a load port for writing the program image.
module mpp_prog_mem #(
   parameter int                   DATA_W      = 8,
   parameter int                   ADDR_W      = 16,
   parameter int                   DEPTH       = 32,
   parameter int                   WAIT_STATES = 1,
   parameter logic [DATA_W-1:0]    FILL        = '0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              prog_cs_n_i,
   input  logic [ADDR_W-1:0] prog_addr_i,
   output logic [DATA_W-1:0] instruction_o,
   output logic              instr_valid_o,
   output logic              busy_o,
   input  logic              ld_en_i,
   input  logic [ADDR_W-1:0] ld_addr_i,
   input  logic [DATA_W-1:0] ld_data_i,
   output logic              ld_err_o
);

   localparam int              IdxW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DepthL   = (ADDR_W + 1)'(DEPTH);
   localparam logic [3:0]      WaitL    = 4'(WAIT_STATES);
   localparam bit              ZeroWait = (WAIT_STATES == 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_DONE
   } state_e;

   state_e              state_q, state_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   instruction_q, instruction_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [3:0]          wcnt_q, wcnt_d;
   logic                ldErr_q, ldErr_d;

   logic                accept;
   logic                ldOk;
   logic                captureEn;
   logic [ADDR_W-1:0]   capAddr;
   logic                capInRange;
   logic                ldInRange;
   logic [DATA_W-1:0]   capData;

   assign accept     = (state_q == S_IDLE) && !prog_cs_n_i;
   assign ldInRange  = ({1'b0, ld_addr_i} < DepthL);
   assign ldOk       = ld_en_i && (state_q == S_IDLE) && prog_cs_n_i && ldInRange;
   // With zero wait states the capture happens on the accept edge, so the
   // address comes straight from the port rather than the latched copy.
   assign capAddr    = (state_q == S_IDLE) ? prog_addr_i : addr_q;
   assign capInRange = ({1'b0, capAddr} < DepthL);
   assign capData    = capInRange ? mem_q[capAddr[IdxW-1:0]] : FILL;
   assign captureEn  = (accept && ZeroWait) ||
                       ((state_q == S_WAIT) && !prog_cs_n_i && (wcnt_q == 4'd1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (!prog_cs_n_i) state_d = ZeroWait ? S_DONE : S_WAIT;
         S_WAIT: begin
            if (prog_cs_n_i)           state_d = S_IDLE;
            else if (wcnt_q == 4'd1)   state_d = S_DONE;
         end
         S_DONE: if (prog_cs_n_i) state_d = S_IDLE;
         default:                      state_d = S_IDLE;
      endcase
   end

   always_comb begin
      instr_valid_o = (state_q == S_DONE);
      busy_o        = (state_q == S_WAIT) || (state_q == S_DONE);
   end

   always_comb begin
      instruction_d = captureEn ? capData : instruction_q;
      addr_d        = accept ? prog_addr_i : addr_q;
      wcnt_d        = wcnt_q;
      if (accept)                  wcnt_d = WaitL;
      else if (state_q == S_WAIT)  wcnt_d = wcnt_q - 4'd1;
      ldErr_d       = ld_en_i && !ldOk;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         instruction_q <= '0;
         addr_q        <= '0;
         wcnt_q        <= '0;
         ldErr_q       <= 1'b0;
      end else begin
         instruction_q <= instruction_d;
         addr_q        <= addr_d;
         wcnt_q        <= wcnt_d;
         ldErr_q       <= ldErr_d;
      end
   end

   // The array has no reset so a boot image survives a mid-fetch reset.
   always_ff @(posedge clk) begin
      if (ldOk) begin
         mem_q[ld_addr_i[IdxW-1:0]] <= ld_data_i;
      end
   end

   assign instruction_o = instruction_q;
   assign ld_err_o      = ldErr_q;

endmodule
